// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - system bus constants and memory responder state type
// Shared with the bus arbiter. Holds the direction encoding of the tag,
// line geometry and the responder FSM state enumeration.
package sysbus_pkg;

    localparam int   SYSBUS_DATA_W     = 64;
    localparam int   SYSBUS_TAG_W      = 13;
    localparam int   SYSBUS_DIR_BIT    = 12;
    localparam logic SYSBUS_WRITE      = 1'b1;
    localparam logic SYSBUS_READ       = 1'b0;
    localparam int   SYSBUS_LINE_BEATS = 8;
    localparam int   SYSBUS_BEAT_W     = $clog2(SYSBUS_LINE_BEATS);
    // Byte offset inside a 512-bit line; these address bits never select a line.
    localparam int   SYSBUS_OFFSET_W   = 6;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        RD_WAIT,
        RD_RESP
    } sysbus_mem_state_t;

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// rtl/sysbus_mem_responder_if.sv - request/response bus between arbiter and memory
// Signals:
//   reqcyc/req/reqtag  requester -> memory, request beat
//   reqack             memory -> requester, beat accepted pulse
//   respcyc/resp/resptag memory -> requester, read data beat
//   respack            requester -> memory, response beat consumed
interface sysbus_mem_responder_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
);

    logic              reqcyc;
    logic              reqack;
    logic [DATA_W-1:0] req;
    logic [TAG_W-1:0]  reqtag;
    logic              respcyc;
    logic              respack;
    logic [DATA_W-1:0] resp;
    logic [TAG_W-1:0]  resptag;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );

endinterface

// File: rtl/sysbus_line_ram.sv
// rtl/sysbus_line_ram.sv - line store, one sync write port and one sync read port
// Ports:
//   clk, reset          clock; reset clears only the read data register
//   wr_en/wr_addr/wr_data  synchronous write
//   rd_en/rd_addr       read request; rd_data updates on the next edge, holds otherwise
//   rd_data             registered read data
module sysbus_line_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage itself is never cleared so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - memory-side end of the system bus backed by a line store
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    slave side of sysbus_mem_responder_if (request in, read response out)
// Writes take an address beat then LINE_BEATS data beats and complete silently.
// Reads take an address beat and return LINE_BEATS beats with the tag echoed.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = SYSBUS_DATA_W,
    parameter int BUS_TAG_WIDTH  = SYSBUS_TAG_W,
    parameter int LINE_BEATS     = SYSBUS_LINE_BEATS,
    parameter int DEPTH_LINES    = 256,
    parameter int READ_LATENCY   = 4
) (
    input logic                   clk,
    input logic                   reset,
    sysbus_mem_responder_if.slave bus
);

    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int LINE_W = $clog2(DEPTH_LINES);
    localparam int LAT_W  = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    sysbus_mem_state_t        state, state_n;
    logic [LINE_W-1:0]        line_q, line_n;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_n;
    logic [BEAT_W-1:0]        beat_q, beat_n;
    logic [LAT_W-1:0]         lat_q, lat_n;
    logic                     reqack_q;
    logic                     respcyc_q;

    logic                      accept;
    logic                      wr_en;
    logic                      rd_en;
    logic [BEAT_W-1:0]         rd_beat;
    logic [BUS_DATA_WIDTH-1:0] rd_data;

    // A beat is only taken when the previous one is not being acked, which
    // caps request throughput at one beat every two cycles.
    assign accept = bus.reqcyc && !reqack_q && (state == IDLE || state == WDATA);

    always_comb begin
        state_n = state;
        line_n  = line_q;
        tag_n   = tag_q;
        beat_n  = beat_q;
        lat_n   = lat_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_beat = beat_q + BEAT_W'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    line_n = bus.req[SYSBUS_OFFSET_W +: LINE_W];
                    if (bus.reqtag[SYSBUS_DIR_BIT] == SYSBUS_WRITE) begin
                        state_n = WDATA;
                        beat_n  = '0;
                    end else begin
                        tag_n   = bus.reqtag;
                        state_n = RD_WAIT;
                        lat_n   = '0;
                    end
                end
            end
            WDATA: begin
                if (accept) begin
                    wr_en  = !reset;
                    beat_n = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
                        state_n = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_q == LAT_W'(READ_LATENCY)) begin
                    // Fetch beat 0 now so it is on resp in the first RD_RESP cycle.
                    state_n = RD_RESP;
                    beat_n  = '0;
                    rd_en   = 1'b1;
                    rd_beat = '0;
                end else begin
                    lat_n = lat_q + LAT_W'(1);
                end
            end
            RD_RESP: begin
                // rd_data only advances on a transfer, so a stall holds resp.
                if (respcyc_q && bus.respack) begin
                    beat_n = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
                        state_n = IDLE;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
        end else begin
            state     <= state_n;
            line_q    <= line_n;
            tag_q     <= tag_n;
            beat_q    <= beat_n;
            lat_q     <= lat_n;
            reqack_q  <= accept;
            respcyc_q <= (state_n == RD_RESP);
        end
    end

    sysbus_line_ram #(
        .DATA_W (BUS_DATA_WIDTH),
        .ADDR_W (LINE_W + BEAT_W)
    ) u_line_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr ({line_q, beat_q}),
        .wr_data (bus.req),
        .rd_en   (rd_en),
        .rd_addr ({line_q, rd_beat}),
        .rd_data (rd_data)
    );

    assign bus.reqack  = reqack_q;
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = rd_data;
    assign bus.resptag = tag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - self-checking bench for sysbus_mem_responder
module tb_sysbus_mem_responder;

    localparam int RL = 4;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [12:0] tag;
        logic [63:0] base;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    sysbus_mem_responder_if #(.DATA_W(64), .TAG_W(13)) bus ();

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .LINE_BEATS     (8),
        .DEPTH_LINES    (256),
        .READ_LATENCY   (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   applied     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    sb_t  sb[$];
    vec_t vecs[8];

    int          ack_cnt     = 0;
    int          adj_err     = 0;
    logic        prev_ack    = 1'b0;
    int          first_resp  = -1;
    int          last_resp   = -1;
    int          resp_hi_cnt = 0;
    int          xfer_cnt    = 0;
    logic        hold_pending = 1'b0;
    logic [63:0] hold_resp;
    logic [12:0] hold_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        sb_t e;
        @(negedge clk);
        if (bus.reqack === 1'b1) begin
            ack_cnt++;
            if (prev_ack) adj_err++;
        end
        prev_ack = bus.reqack;
        if (bus.respcyc === 1'b1) begin
            if (first_resp < 0) first_resp = cyc;
            last_resp = cyc;
            resp_hi_cnt++;
        end
        if (hold_pending && bus.respcyc === 1'b1) begin
            check("resp_hold", bus.resp, hold_resp);
            check("resptag_hold", 64'(bus.resptag), 64'(hold_tag));
        end
        hold_pending = (bus.respcyc === 1'b1) && !bus.respack && !reset;
        hold_resp    = bus.resp;
        hold_tag     = bus.resptag;
        if (bus.respcyc === 1'b1 && bus.respack && !reset) begin
            xfer_cnt++;
            if (sb.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL sb_underflow: got beat 0x%0h, expected no beat", bus.resp);
            end else begin
                e = sb.pop_front();
                check("resp", bus.resp, e.data);
                check("resptag", 64'(bus.resptag), 64'(e.tag));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, expected finish before 800000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output int ack_c);
        bus.reqcyc = 1'b1;
        bus.req    = d;
        bus.reqtag = t;
        ack_c      = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.reqack === 1'b1) begin
                ack_c = cyc;
                break;
            end
        end
        if (ack_c < 0) begin
            applied++;
            miscompares++;
            $display("FAIL reqack_timeout: got no ack, expected ack within 200 cycles");
        end
        step();
    endtask

    task automatic write_data(input logic [63:0] base);
        int c;
        for (int i = 0; i < 8; i++) begin
            send_beat(base + 64'(i), 13'($urandom_range(0, 8191)), c);
        end
        bus.reqcyc = 1'b0;
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base);
        int c;
        send_beat(addr, tag, c);
        write_data(base);
    endtask

    task automatic push_exp(input logic [63:0] base, input logic [12:0] tag);
        for (int i = 0; i < 8; i++) sb.push_back('{base + 64'(i), tag});
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            if (sb.size() == 0 && bus.respcyc !== 1'b1) break;
            step();
        end
        if (k == 300) begin
            applied++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base,
                             output int ack_c);
        push_exp(base, tag);
        send_beat(addr, tag, ack_c);
        bus.reqcyc = 1'b0;
        drain();
    endtask

    initial begin
        int ack_c;
        int ack_c2;
        int stalls;
        int k;

        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b1;
        reset       = 1'b1;

        vecs[0] = '{1'b1, 64'h0000_0000_0000_0140, 13'h1001, 64'h0000_0000_0000_5000};
        vecs[1] = '{1'b0, 64'h0000_0000_0000_0140, 13'h0005, 64'h0000_0000_0000_5000};
        vecs[2] = '{1'b1, 64'h0000_0000_0000_40C0, 13'h1ABC, 64'h0123_4567_0000_3300};
        vecs[3] = '{1'b0, 64'h0000_0000_0000_00C5, 13'h0ABC, 64'h0123_4567_0000_3300};
        vecs[4] = '{1'b1, 64'h0000_0000_0000_3FC0, 13'h1FFF, 64'hFFFF_0000_FF00_0000};
        vecs[5] = '{1'b0, 64'h0000_0000_0010_3FC0, 13'h0FFF, 64'hFFFF_0000_FF00_0000};
        vecs[6] = '{1'b1, 64'h0000_0000_0000_0140, 13'h1000, 64'hCAFE_0000_0000_7700};
        vecs[7] = '{1'b0, 64'h0000_0000_0000_0157, 13'h0123, 64'hCAFE_0000_0000_7700};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_reqack", 64'(bus.reqack), 64'd0);
        check("reset_respcyc", 64'(bus.respcyc), 64'd0);
        check("reset_resp", bus.resp, 64'd0);
        check("reset_resptag", 64'(bus.resptag), 64'd0);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) write_line(vecs[i].addr, vecs[i].tag, vecs[i].base);
            else            read_line(vecs[i].addr, vecs[i].tag, vecs[i].base, ack_c);
        end

        first_resp  = -1;
        resp_hi_cnt = 0;
        read_line(64'h140, 13'h0042, 64'hCAFE_0000_0000_7700, ack_c);
        check("lat_first_respcyc", 64'(first_resp), 64'(ack_c + 1 + RL));
        check("lat_last_respcyc", 64'(last_resp), 64'(ack_c + 8 + RL));
        check("lat_respcyc_cycles", 64'(resp_hi_cnt), 64'd8);

        write_line(64'd9 << 6, 13'h1009, 64'h9999_0000_0000_0900);
        push_exp(64'h9999_0000_0000_0900, 13'h0009);
        xfer_cnt = 0;
        stalls   = 0;
        send_beat(64'd9 << 6, 13'h0009, ack_c);
        bus.reqcyc = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (sb.size() == 0 && bus.respcyc !== 1'b1) break;
            if (bus.respcyc === 1'b1 && xfer_cnt == 2 && stalls < 3) begin
                bus.respack = 1'b0;
                stalls++;
                check("stall_beat2", bus.resp, 64'h9999_0000_0000_0902);
            end else begin
                bus.respack = 1'b1;
            end
            step();
        end
        bus.respack = 1'b1;
        check("stall_cycles", 64'(stalls), 64'd3);
        check("stall_transfers", 64'(xfer_cnt), 64'd8);

        ack_cnt = 0;
        adj_err = 0;
        write_line(64'd10 << 6, 13'h100A, 64'h1010_0000_0000_0A00);
        check("wr_ack_count", 64'(ack_cnt), 64'd9);
        check("wr_ack_adjacent", 64'(adj_err), 64'd0);
        read_line(64'd10 << 6, 13'h000A, 64'h1010_0000_0000_0A00, ack_c);

        push_exp(64'h1010_0000_0000_0A00, 13'h0A0A);
        send_beat(64'd10 << 6, 13'h0A0A, ack_c);
        send_beat(64'd12 << 6, 13'h100C, ack_c2);
        check("pending_ack_cycle", 64'(ack_c2), 64'(last_resp + 2));
        check("pending_sb_empty", 64'(sb.size()), 64'd0);
        write_data(64'h1212_0000_0000_0C00);
        read_line(64'd12 << 6, 13'h000C, 64'h1212_0000_0000_0C00, ack_c);

        write_line(64'd11 << 6, 13'h100B, 64'hB0B0_0000_0000_1100);
        push_exp(64'hB0B0_0000_0000_1100, 13'h000B);
        xfer_cnt = 0;
        send_beat(64'd11 << 6, 13'h000B, ack_c);
        bus.reqcyc = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (xfer_cnt == 4 && bus.respcyc === 1'b1) break;
            step();
        end
        check("reset_at_beat4_reached", 64'(xfer_cnt), 64'd4);
        reset       = 1'b1;
        bus.respack = 1'b0;
        step();
        check("midreset_respcyc", 64'(bus.respcyc), 64'd0);
        check("midreset_reqack", 64'(bus.reqack), 64'd0);
        check("midreset_resp", bus.resp, 64'd0);
        sb.delete();
        reset       = 1'b0;
        bus.respack = 1'b1;
        step();
        read_line(64'd11 << 6, 13'h0B0B, 64'hB0B0_0000_0000_1100, ack_c);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
